// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory port between two requesters,
// performs sub-word stores as read-modify-write and formats load data.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration (default: port 0 fixed priority).
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_we0,
  input  logic             i_we1,
  input  logic [1:0]       i_size0,
  input  logic [1:0]       i_size1,
  input  logic             i_uns0,
  input  logic             i_uns1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_wd0,
  input  logic [WIDTH-1:0] i_wd1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_valid0,
  output logic             o_valid1,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_mem_a,
  output logic [WIDTH-1:0] o_mem_wd,
  output logic             o_mem_we,
  input  logic [WIDTH-1:0] i_mem_rd,
  output logic [1:0]       o_dbg_state
);

  // Handshake: REQx stays high until GNTx; GNTx pulses once when the operands are
  // latched, VALIDx pulses once on completion with RDATA valid in that same cycle.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_MERGE_WR = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic             r_port, r_we, r_uns;
  logic [1:0]       r_size;
  logic [15:0]      r_wd;
  logic             r_gnt0, r_gnt1, r_valid0, r_valid1, r_mem_we;
  logic [WIDTH-1:0] r_mem_a, r_mem_wd, r_rdata;

  logic             w_any_req, w_win, w_win_we, w_win_uns, w_win_sub, w_sub_word;
  logic [1:0]       w_win_size;
  logic [WIDTH-1:0] w_win_a, w_win_wd, w_load_fmt, w_merge;

  assign w_any_req = i_req0 | i_req1;

`ifdef DMEM_ARB_RR_EN
  logic r_last;

  assign w_win = (i_req0 && i_req1) ? ~r_last : i_req1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_last <= 1'b1;
    else if (r_state == S_IDLE && w_any_req) r_last <= w_win;
  end
`else
  assign w_win = ~i_req0;
`endif

  assign w_win_we   = w_win ? i_we1   : i_we0;
  assign w_win_size = w_win ? i_size1 : i_size0;
  assign w_win_uns  = w_win ? i_uns1  : i_uns0;
  assign w_win_a    = w_win ? i_a1    : i_a0;
  assign w_win_wd   = w_win ? i_wd1   : i_wd0;
  assign w_win_sub  = (w_win_size == 2'b00) || (w_win_size == 2'b01);
  assign w_sub_word = (r_size == 2'b00) || (r_size == 2'b01);

  always_comb begin
    w_load_fmt = i_mem_rd;
    case (r_size)
      2'b00:   w_load_fmt = {{(WIDTH-8){i_mem_rd[7] & ~r_uns}}, i_mem_rd[7:0]};
      2'b01:   w_load_fmt = {{(WIDTH-16){i_mem_rd[15] & ~r_uns}}, i_mem_rd[15:0]};
      default: w_load_fmt = i_mem_rd;
    endcase
  end

  // Merge keeps the untouched upper bytes of the word currently at the latched address.
  assign w_merge = (r_size == 2'b00) ? {i_mem_rd[WIDTH-1:8], r_wd[7:0]}
                                     : {i_mem_rd[WIDTH-1:16], r_wd[15:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_any_req) w_next = S_ACCESS;
      S_ACCESS:   w_next = (r_we && w_sub_word) ? S_MERGE_WR : S_DONE;
      S_MERGE_WR: w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // r_mem_wd doubles as the merge register for sub-word stores.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_size   <= 2'b00;
      r_wd     <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      r_rdata  <= '0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_port  <= w_win;
            r_we    <= w_win_we;
            r_size  <= w_win_size;
            r_uns   <= w_win_uns;
            r_wd    <= w_win_wd[15:0];
            r_mem_a <= w_win_a;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            if (w_win_we && !w_win_sub) begin
              r_mem_we <= 1'b1;
              r_mem_wd <= w_win_wd;
            end
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_load_fmt;
          end else if (w_sub_word) begin
            r_mem_wd <= w_merge;
            r_mem_we <= 1'b1;
          end
        end
        default: ;
      endcase
      if (w_next == S_DONE) begin
        r_valid0 <= ~r_port;
        r_valid1 <= r_port;
      end
    end
  end

  assign o_gnt0      = r_gnt0;
  assign o_gnt1      = r_gnt1;
  assign o_valid0    = r_valid0;
  assign o_valid1    = r_valid1;
  assign o_rdata     = r_rdata;
  assign o_busy      = (r_state != S_IDLE);
  assign o_mem_a     = r_mem_a;
  assign o_mem_wd    = r_mem_wd;
  assign o_mem_we    = r_mem_we;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array memory, transaction-level model with a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        req0, req1, we0, we1, uns0, uns1;
  logic [1:0]  size0, size1;
  logic [31:0] a0, a1, wd0, wd1;
  logic        o_gnt0, o_gnt1, o_valid0, o_valid1, o_busy, o_mem_we;
  logic [31:0] o_rdata, o_mem_a, o_mem_wd, mem_rd;
  logic [1:0]  o_dbg_state;

  dmem_arbiter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_size0(size0), .i_size1(size1), .i_uns0(uns0), .i_uns1(uns1),
    .i_a0(a0), .i_a1(a1), .i_wd0(wd0), .i_wd1(wd1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_valid0(o_valid0), .o_valid1(o_valid1),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_mem_a(o_mem_a), .o_mem_wd(o_mem_wd),
    .o_mem_we(o_mem_we), .i_mem_rd(mem_rd), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters and check helpers ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endfunction

  // ---------------- physical memory (low 8 address bits, unaligned word access) ----------------
  logic [7:0]  mem [256];
  logic        bd_we;
  logic [31:0] bd_a, bd_d;
  logic [7:0]  ma;

  assign ma     = o_mem_a[7:0];
  assign mem_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (o_mem_we) begin
        for (int b = 0; b < 4; b++) mem[ma + 8'(b)] = o_mem_wd[8*b +: 8];
      end else if (bd_we) begin
        for (int b = 0; b < 4; b++) mem[bd_a[7:0] + 8'(b)] = bd_d[8*b +: 8];
      end
    end
  end

  function automatic logic [7:0] peek_byte(input logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  function automatic logic [31:0] peek_word(input logic [31:0] a);
    return {peek_byte(a + 3), peek_byte(a + 2), peek_byte(a + 1), peek_byte(a)};
  endfunction

  // ---------------- model + scoreboard ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_q[$];
  int          gnt_log[$];
  int          cyc, g_cyc, w_cyc, v_cyc, v1_cnt;
  logic [31:0] w_wd;
  bit          has_txn;
  logic        m_last, t_port, t_we, t_uns;
  logic [1:0]  t_size;
  logic [31:0] t_a, t_wd;
  int          t_s, t_len;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [7:0] x;
    x = a[7:0];
    return {ref_mem[x + 8'd3], ref_mem[x + 8'd2], ref_mem[x + 8'd1], ref_mem[x]};
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int b = 0; b < n; b++) ref_mem[a[7:0] + 8'(b)] = d[8*b +: 8];
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] s, input logic u);
    if (s == 2'b00) return u ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
    if (s == 2'b01) return u ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  initial begin
    int   k;
    bit   act, sub, e_we;
    logic p;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    has_txn = 0; m_last = 1'b1; cyc = 0; v1_cnt = 0;
    g_cyc = 0; w_cyc = 0; v_cyc = 0; w_wd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_gnt0 || o_gnt1) begin gnt_log.push_back(o_gnt1 ? 1 : 0); g_cyc = cyc; end
      if (o_mem_we) begin w_cyc = cyc; w_wd = o_mem_wd; end
      if (o_valid0 || o_valid1) v_cyc = cyc;
      if (o_valid1) v1_cnt++;
      if (!rst_n) begin
        has_txn = 0; m_last = 1'b1; exp_q.delete();
        chk1("rst_gnt0", o_gnt0, 1'b0);
        chk1("rst_gnt1", o_gnt1, 1'b0);
        chk1("rst_valid0", o_valid0, 1'b0);
        chk1("rst_valid1", o_valid1, 1'b0);
        chk1("rst_mem_we", o_mem_we, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_state", {30'h0, o_dbg_state}, 32'h0);
      end else begin
        if (bd_we) ref_store(bd_a, bd_d, 4);
        k   = cyc - t_s;
        act = has_txn && (k < t_len);
        sub = (t_size == 2'b00) || (t_size == 2'b01);
        e_we = act && t_we && ((!sub && k == 1) || (sub && k == 2));
        chk1("gnt0",   o_gnt0,   act && k == 1 && !t_port);
        chk1("gnt1",   o_gnt1,   act && k == 1 &&  t_port);
        chk1("valid0", o_valid0, act && k == t_len - 1 && !t_port);
        chk1("valid1", o_valid1, act && k == t_len - 1 &&  t_port);
        chk1("busy",   o_busy,   act && k >= 1);
        chk1("mem_we", o_mem_we, e_we);
        if (e_we) begin
          ref_store(t_a, t_wd, nbytes(t_size));
          chk("mem_a", o_mem_a, t_a);
          chk("mem_wd", o_mem_wd, ref_rd(t_a));
        end
        if (act && k == t_len - 1 && !t_we) begin
          if (exp_q.size() == 0) note_fail("rdata_queue_empty");
          else chk("rdata", o_rdata, exp_q.pop_front());
        end
        if ((!has_txn || k >= t_len) && (req0 || req1)) begin
`ifdef DMEM_ARB_RR_EN
          p = (req0 && req1) ? ~m_last : req1;
          m_last = p;
`else
          p = req0 ? 1'b0 : 1'b1;
`endif
          t_port = p;
          t_we   = p ? we1   : we0;
          t_size = p ? size1 : size0;
          t_uns  = p ? uns1  : uns0;
          t_a    = p ? a1    : a0;
          t_wd   = p ? wd1   : wd0;
          t_s    = cyc;
          has_txn = 1;
          t_len  = (t_we && (t_size == 2'b00 || t_size == 2'b01)) ? 4 : 3;
          if (!t_we) exp_q.push_back(fmt(ref_rd(t_a), t_size, t_uns));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_txn(input int p, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit got;
    rd = '0;
    if (p == 0) begin we0 = we; size0 = size; uns0 = uns; a0 = a; wd0 = wd; req0 = 1'b1; end
    else        begin we1 = we; size1 = size; uns1 = uns; a1 = a; wd1 = wd; req1 = 1'b1; end
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      got = (p == 0) ? o_gnt0 : o_gnt1;
    end
    // Scramble operands after the grant; the transaction in flight must not see them.
    if (p == 0) begin req0 = 1'b0; we0 = ~we; size0 = ~size; uns0 = ~uns; a0 = ~a; wd0 = ~wd; end
    else        begin req1 = 1'b0; we1 = ~we; size1 = ~size; uns1 = ~uns; a1 = ~a; wd1 = ~wd; end
    if (!got) begin
      note_fail("gnt_timeout");
      return;
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = (p == 0) ? o_valid0 : o_valid1;
      if (got) rd = o_rdata;
    end
    if (!got) note_fail("valid_timeout");
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] rd, rd0, rd1;
  int          base, v1_base;
  int          exp_order[$];
  bit          got;

  initial begin
    rst_n = 1'b0; bd_we = 1'b0; bd_a = '0; bd_d = '0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; uns0 = 0; uns1 = 0;
    size0 = 2'b10; size1 = 2'b10; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_state", {30'h0, o_dbg_state}, 32'h0);
    chk1("reset_busy", o_busy, 1'b0);

    // word store then word load on port 0
    do_txn(0, 1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, rd);
    @(negedge clk); #1;
    chk("wst_we_lat", w_cyc - g_cyc, 0);
    chk("wst_valid_lat", v_cyc - g_cyc, 1);
    chk("wst_wd", w_wd, 32'hDEAD_BEEF);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, rd);
    chk("wld_rdata", rd, 32'hDEAD_BEEF);

    // byte store read-modify-write
    poke(32'h0001_0004, 32'h1122_3344);
    do_txn(0, 1'b1, 2'b00, 1'b0, 32'h0001_0004, 32'h0000_00AA, rd);
    @(negedge clk); #1;
    chk("bst_we_lat", w_cyc - g_cyc, 1);
    chk("bst_valid_lat", v_cyc - g_cyc, 2);
    chk("bst_merge_wd", w_wd, 32'h1122_33AA);
    chk("bst_mem", peek_word(32'h0001_0004), 32'h1122_33AA);

    // load formatting
    poke(32'h0001_0008, 32'h0000_80F0);
    do_txn(0, 1'b0, 2'b00, 1'b0, 32'h0001_0008, 32'h0, rd); chk("ld_sbyte", rd, 32'hFFFF_FFF0);
    do_txn(1, 1'b0, 2'b00, 1'b1, 32'h0001_0008, 32'h0, rd); chk("ld_ubyte", rd, 32'h0000_00F0);
    do_txn(0, 1'b0, 2'b01, 1'b0, 32'h0001_0008, 32'h0, rd); chk("ld_shalf", rd, 32'hFFFF_80F0);
    do_txn(1, 1'b0, 2'b01, 1'b1, 32'h0001_0008, 32'h0, rd); chk("ld_uhalf", rd, 32'h0000_80F0);
    do_txn(0, 1'b0, 2'b11, 1'b0, 32'h0001_0008, 32'h0, rd); chk("ld_size3", rd, 32'h0000_80F0);

    // unaligned half store
    poke(32'h0001_0011, 32'h1122_3344);
    do_txn(0, 1'b1, 2'b01, 1'b0, 32'h0001_0011, 32'h5A5A_BEEF, rd);
    chk("ua_b0", {24'h0, peek_byte(32'h0001_0011)}, 32'hEF);
    chk("ua_b1", {24'h0, peek_byte(32'h0001_0012)}, 32'hBE);
    chk("ua_b2", {24'h0, peek_byte(32'h0001_0013)}, 32'h22);
    chk("ua_b3", {24'h0, peek_byte(32'h0001_0014)}, 32'h11);
    do_txn(1, 1'b0, 2'b10, 1'b0, 32'h0001_0011, 32'h0, rd); chk("ua_word", rd, 32'h1122_BEEF);

    // reset asserted during MERGE_WR of a byte store on port 1
    poke(32'h0001_0020, 32'hCAFE_F00D);
    v1_base = v1_cnt;
    @(posedge clk); #1;
    we1 = 1'b1; size1 = 2'b00; uns1 = 1'b0; a1 = 32'h0001_0020; wd1 = 32'h55; req1 = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = o_gnt1;
    end
    req1 = 1'b0;
    if (!got) note_fail("rst_gnt_timeout");
    @(posedge clk); #1;
    chk1("merge_we_before_rst", o_mem_we, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk1("rst_we_drop", o_mem_we, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_mem_unchanged", peek_word(32'h0001_0020), 32'hCAFE_F00D);
    chk("rst_no_valid", v1_cnt - v1_base, 0);
    chk("rst_state_idle", {30'h0, o_dbg_state}, 32'h0);
    chk1("rst_busy_idle", o_busy, 1'b0);

    // contention: both ports requesting
    base = gnt_log.size();
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
    fork
      begin for (int i = 0; i < 2; i++) do_txn(0, 1'b0, 2'b10, 1'b0, 32'h0001_0000 + 32'(4*i), 32'h0, rd0); end
      begin for (int i = 0; i < 2; i++) do_txn(1, 1'b0, 2'b10, 1'b0, 32'h0001_0008 + 32'(4*i), 32'h0, rd1); end
    join
`else
    exp_order = '{0, 0, 0, 0, 1};
    fork
      begin for (int i = 0; i < 4; i++) do_txn(0, 1'b0, 2'b10, 1'b0, 32'h0001_0000 + 32'(4*i), 32'h0, rd0); end
      begin do_txn(1, 1'b0, 2'b01, 1'b1, 32'h0001_0011, 32'h0, rd1); end
    join
    chk("cont_p1_rdata", rd1, 32'h0000_BEEF);
`endif
    @(negedge clk); #1;
    chk("cont_count", gnt_log.size() - base, exp_order.size());
    if (gnt_log.size() - base == exp_order.size()) begin
      foreach (exp_order[i]) chk("cont_order", gnt_log[base + i], exp_order[i]);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
